// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default rate constants and the
// baud divider calculation, reused by the receiver and the future transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_e;

    localparam int UART_DEFAULT_CLK_HZ     = 50_000_000;
    localparam int UART_DEFAULT_BAUD       = 115_200;
    localparam int UART_DEFAULT_OVERSAMPLE = 16;

    // Clock cycles per oversample tick (integer division, truncating).
    function automatic int uart_div(input int clk_hz, input int baud, input int os);
        return clk_hz / (baud * os);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick_o every DIV clocks, where
// DIV = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE). Shared with the transmitter.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = UART_DEFAULT_CLK_HZ,
    parameter int BAUD_RATE   = UART_DEFAULT_BAUD,
    parameter int OVERSAMPLE  = UART_DEFAULT_OVERSAMPLE
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int DIV   = uart_div(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    generate
        if (DIV < 1) begin : g_div_check
            $error("uart_baud_tick: CLK_FREQ_HZ too low for BAUD_RATE*OVERSAMPLE");
        end
    endgenerate

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == CNT_LAST);
    assign tick_o = w_last;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver (8N1 by default) with a one-entry valid/ready
// output register. Define UART_RX_PARITY_EN to add a parity bit (8E1/8O1).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = UART_DEFAULT_CLK_HZ,
    parameter int BAUD_RATE   = UART_DEFAULT_BAUD,
    parameter int OVERSAMPLE  = UART_DEFAULT_OVERSAMPLE,
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD  = 1'b0
`endif
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 overrun_o,
    output logic [2:0]           dbg_state_o
);

    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    generate
        if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_os_check
            $error("uart_rx: OVERSAMPLE must be even and >= 4");
        end
        if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bits_check
            $error("uart_rx: DATA_BITS must be 5..8");
        end
        if (SYNC_STAGES < 2) begin : g_sync_check
            $error("uart_rx: SYNC_STAGES must be >= 2");
        end
    endgenerate

    // Line synchroniser; resets to the idle (high) level.
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rx_s;
    logic                   w_tick;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign w_rx_s = r_sync[SYNC_STAGES-1];

    uart_baud_tick #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .BAUD_RATE   (BAUD_RATE),
        .OVERSAMPLE  (OVERSAMPLE)
    ) u_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tick_o (w_tick)
    );

    uart_state_e          r_state, w_state_nxt;
    logic [OS_W-1:0]      r_os_cnt, w_os_nxt;
    logic [BIT_W-1:0]     r_bit_cnt, w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                 w_os_last;
    logic                 w_load;
    logic                 w_load_ferr;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_err, w_par_nxt;
`endif

    assign w_os_last   = (r_os_cnt == OS_LAST);
    assign dbg_state_o = r_state;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_os_cnt  <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
`ifdef UART_RX_PARITY_EN
            r_par_err <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_os_cnt  <= w_os_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
`ifdef UART_RX_PARITY_EN
            r_par_err <= w_par_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_os_nxt    = r_os_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_load      = 1'b0;
        w_load_ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_nxt   = r_par_err;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_tick && !w_rx_s) begin
                    w_state_nxt = ST_START;
                    w_os_nxt    = '0;
                end
            end
            ST_START: begin
                // Re-check the line at mid start bit to reject short glitches.
                if (w_tick) begin
                    if (r_os_cnt == OS_MID) begin
                        w_os_nxt  = '0;
                        w_bit_nxt = '0;
                        w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        w_os_nxt = r_os_cnt + OS_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (w_os_last) begin
                        w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
                        w_os_nxt    = '0;
                        if (r_bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            w_state_nxt = ST_PARITY;
`else
                            w_state_nxt = ST_STOP;
`endif
                        end else begin
                            w_bit_nxt = r_bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        w_os_nxt = r_os_cnt + OS_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) begin
                    if (w_os_last) begin
                        w_par_nxt   = w_rx_s ^ (^r_shift) ^ PARITY_ODD;
                        w_os_nxt    = '0;
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_os_nxt = r_os_cnt + OS_W'(1);
                    end
                end
            end
`endif
            ST_STOP: begin
                if (w_tick) begin
                    if (w_os_last) begin
                        w_load      = 1'b1;
                        w_load_ferr = ~w_rx_s;
                        w_os_nxt    = '0;
                        w_state_nxt = w_rx_s ? ST_IDLE : ST_BREAK;
                    end else begin
                        w_os_nxt = r_os_cnt + OS_W'(1);
                    end
                end
            end
            ST_BREAK: begin
                // A held-low line yields one framing error, not a frame stream.
                if (w_rx_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output register. valid/ready: a frame is transferred on any edge where
    // valid_o & ready_i; a new frame arriving while one is still unaccepted is
    // dropped and flagged by a one-cycle overrun_o pulse.
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_overrun;
    logic                 w_accept;
    logic                 w_drop;

    assign w_accept = r_valid & ready_i;
    assign w_drop   = w_load & r_valid & ~ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= w_drop;
            if (w_load && !w_drop) begin
                r_data      <= r_shift;
                r_frame_err <= w_load_ferr;
                r_valid     <= 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_parity_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_parity_err <= 1'b0;
        end else if (w_load && !w_drop) begin
            r_parity_err <= r_par_err;
        end
    end

    assign parity_err_o = r_parity_err;
`else
    assign parity_err_o = 1'b0;
`endif

    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 7.3728 MHz / 115200 baud / x16 (64 clk
// per bit). Frames are predicted from the bits put on the line.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CLK_HZ   = 7_372_800;
    localparam int BAUD     = 115_200;
    localparam int OS       = 16;
    localparam int DBITS    = 8;
    localparam int BIT_CLKS = CLK_HZ / BAUD;
    localparam int W        = DBITS + 2;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             rx_i = 1'b1;
    logic             ready_i = 1'b0;
    logic [DBITS-1:0] data_o;
    logic             valid_o;
    logic             frame_err_o;
    logic             parity_err_o;
    logic             overrun_o;
    logic [2:0]       dbg_state_o;

    int n_checks = 0;
    int n_bad    = 0;
    int ovr_cnt  = 0;
    int lat      = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];

    uart_rx #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD_RATE   (BAUD),
        .OVERSAMPLE  (OS),
        .DATA_BITS   (DBITS),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .rx_i         (rx_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o),
        .overrun_o    (overrun_o),
        .dbg_state_o  (dbg_state_o)
    );

    always #5 clk = ~clk;

    // Collect every accepted frame and every overrun cycle.
    always @(negedge clk) begin
        if (!rst_i && valid_o && ready_i) got_q.push_back({parity_err_o, frame_err_o, data_o});
        if (overrun_o) ovr_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got %0t want finish", $time);
        $fatal(1, "watchdog");
    end

    // Expected frame: {parity error, frame error, data}. Even parity.
    function automatic logic [W-1:0] model_frame(input logic [DBITS-1:0] d, input logic stop_b,
                                                 input logic par_b);
        logic perr;
        perr = PAR_EN && (par_b != (^d));
        return {perr, ~stop_b, d};
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives start, LSB-first data, optional parity and stop; leaves rx at the stop level.
    task automatic send_frame(input logic [DBITS-1:0] d, input logic stop_b, input logic par_b);
        rx_i = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < DBITS; i++) begin
            rx_i = d[i];
            wait_clks(BIT_CLKS);
        end
        if (PAR_EN) begin
            rx_i = par_b;
            wait_clks(BIT_CLKS);
        end
        rx_i = stop_b;
        wait_clks(BIT_CLKS);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        ready_i = 1'b0;
        rx_i = 1'b1;
        wait_clks(5);
        n_checks++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_checks++; if (data_o !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 00", data_o); end
        n_checks++; if (frame_err_o !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b want 0", frame_err_o); end
        n_checks++; if (parity_err_o !== 1'b0) begin n_bad++; $display("FAIL reset_perr: got %b want 0", parity_err_o); end
        n_checks++; if (overrun_o !== 1'b0) begin n_bad++; $display("FAIL reset_ovr: got %b want 0", overrun_o); end
        n_checks++; if (dbg_state_o !== ST_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state_o, ST_IDLE); end
        rst_i = 1'b0;
        wait_clks(BIT_CLKS);
    endtask

    task automatic test_basic();
        logic [W-1:0] exp;
        int lat_nom;
        ready_i = 1'b1;
        got_q.delete();
        ovr_cnt = 0;
        exp = model_frame(8'hA5, 1'b1, ^8'hA5);
        lat_nom = BIT_CLKS * (DBITS + 1 + int'(PAR_EN)) + BIT_CLKS / 2;
        fork
            send_frame(8'hA5, 1'b1, ^8'hA5);
            begin
                lat = 0;
                while (valid_o !== 1'b1 && lat < 2000) begin
                    @(posedge clk); #1;
                    lat++;
                end
            end
        join
        rx_i = 1'b1;
        wait_clks(BIT_CLKS);
        n_checks++; if (got_q.size() != 1) begin n_bad++; $display("FAIL basic_count: got %0d want 1", got_q.size()); end
        n_checks++; if (got_q.size() > 0 && got_q[0] !== exp) begin n_bad++; $display("FAIL basic_frame: got %h want %h", got_q[0], exp); end
        n_checks++; if (ovr_cnt != 0) begin n_bad++; $display("FAIL basic_ovr: got %0d want 0", ovr_cnt); end
        n_checks++;
        if (lat < lat_nom || lat > lat_nom + 12) begin
            n_bad++; $display("FAIL basic_latency: got %0d want %0d..%0d", lat, lat_nom, lat_nom + 12);
        end
    endtask

    task automatic test_glitch();
        logic saw_start;
        got_q.delete();
        saw_start = 1'b0;
        rx_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            wait_clks(1);
            if (dbg_state_o === ST_START) saw_start = 1'b1;
        end
        rx_i = 1'b1;
        for (int i = 0; i < 80; i++) begin
            wait_clks(1);
            if (dbg_state_o === ST_START) saw_start = 1'b1;
        end
        n_checks++; if (saw_start !== 1'b1) begin n_bad++; $display("FAIL glitch_start: got %b want 1", saw_start); end
        n_checks++; if (dbg_state_o !== ST_IDLE) begin n_bad++; $display("FAIL glitch_state: got %0d want %0d", dbg_state_o, ST_IDLE); end
        n_checks++; if (got_q.size() != 0) begin n_bad++; $display("FAIL glitch_count: got %0d want 0", got_q.size()); end
    endtask

    task automatic test_break();
        logic [W-1:0] exp;
        got_q.delete();
        exp = model_frame(8'h3C, 1'b0, ^8'h3C);
        send_frame(8'h3C, 1'b0, ^8'h3C);
        wait_clks(10 * BIT_CLKS);
        n_checks++; if (dbg_state_o !== ST_BREAK) begin n_bad++; $display("FAIL break_state: got %0d want %0d", dbg_state_o, ST_BREAK); end
        wait_clks(10 * BIT_CLKS);
        n_checks++; if (got_q.size() != 1) begin n_bad++; $display("FAIL break_count: got %0d want 1", got_q.size()); end
        n_checks++; if (got_q.size() > 0 && got_q[0] !== exp) begin n_bad++; $display("FAIL break_frame: got %h want %h", got_q[0], exp); end
        rx_i = 1'b1;
        wait_clks(2 * BIT_CLKS);
        n_checks++; if (got_q.size() != 1) begin n_bad++; $display("FAIL break_after: got %0d want 1", got_q.size()); end
        n_checks++; if (dbg_state_o !== ST_IDLE) begin n_bad++; $display("FAIL break_idle: got %0d want %0d", dbg_state_o, ST_IDLE); end
    endtask

    task automatic test_overrun();
        logic [W-1:0] exp;
        ready_i = 1'b0;
        got_q.delete();
        ovr_cnt = 0;
        exp = model_frame(8'h11, 1'b1, ^8'h11);
        send_frame(8'h11, 1'b1, ^8'h11);
        send_frame(8'h22, 1'b1, ^8'h22);
        wait_clks(BIT_CLKS);
        n_checks++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL ovr_valid: got %b want 1", valid_o); end
        n_checks++; if ({parity_err_o, frame_err_o, data_o} !== exp) begin
            n_bad++; $display("FAIL ovr_kept: got %h want %h", {parity_err_o, frame_err_o, data_o}, exp);
        end
        n_checks++; if (ovr_cnt != 1) begin n_bad++; $display("FAIL ovr_pulses: got %0d want 1", ovr_cnt); end
        n_checks++; if (got_q.size() != 0) begin n_bad++; $display("FAIL ovr_early: got %0d want 0", got_q.size()); end
        ready_i = 1'b1;
        wait_clks(1);
        n_checks++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL ovr_clear: got %b want 0", valid_o); end
        n_checks++; if (got_q.size() != 1 || got_q[0] !== exp) begin
            n_bad++; $display("FAIL ovr_accept: got n=%0d want n=1 frame %h", got_q.size(), exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] exp;
        ready_i = 1'b1;
        got_q.delete();
        fork
            send_frame(8'hFF, 1'b1, ^8'hFF);
            begin
                wait_clks(4 * BIT_CLKS);
                rst_i = 1'b1;
                wait_clks(1);
                rst_i = 1'b0;
            end
        join
        wait_clks(2 * BIT_CLKS);
        n_checks++; if (got_q.size() != 0) begin n_bad++; $display("FAIL rstmid_drop: got %0d want 0", got_q.size()); end
        n_checks++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b want 0", valid_o); end
        exp = model_frame(8'h5A, 1'b1, ^8'h5A);
        send_frame(8'h5A, 1'b1, ^8'h5A);
        wait_clks(BIT_CLKS);
        n_checks++; if (got_q.size() != 1 || got_q[0] !== exp) begin
            n_bad++; $display("FAIL rstmid_next: got n=%0d want n=1 frame %h", got_q.size(), exp);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        ready_i = 1'b1;
        got_q.delete();
        send_frame(8'h07, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1);
        wait_clks(BIT_CLKS);
        n_checks++; if (got_q.size() != 2) begin n_bad++; $display("FAIL par_count: got %0d want 2", got_q.size()); end
        n_checks++; if (got_q.size() > 0 && got_q[0][W-1] !== 1'b1) begin n_bad++; $display("FAIL par_bad: got %b want 1", got_q[0][W-1]); end
        n_checks++; if (got_q.size() > 1 && got_q[1][W-1] !== 1'b0) begin n_bad++; $display("FAIL par_good: got %b want 0", got_q[1][W-1]); end
    endtask
`endif

    task automatic test_random();
        logic [DBITS-1:0] d;
        logic stop_b;
        logic par_b;
        ready_i = 1'b1;
        got_q.delete();
        exp_q.delete();
        for (int n = 0; n < 24; n++) begin
            d = DBITS'($urandom_range(0, 255));
            stop_b = ($urandom_range(0, 7) != 0);
            par_b = PAR_EN ? 1'($urandom_range(0, 1)) : ^d;
            exp_q.push_back(model_frame(d, stop_b, par_b));
            send_frame(d, stop_b, par_b);
            rx_i = 1'b1;
            wait_clks($urandom_range(8, 40));
        end
        wait_clks(BIT_CLKS);
        n_checks++; if (got_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL rand_frame[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_break();
        test_overrun();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
